pausable_counter: RTL and testbench
===================================

Name: pausable_counter

Overview:
- Synchronous up-counter with enable and pause controls; presents its current count on `cnt_data`.
- Used as a free-running event/tick counter in small control datapaths.
- Wraps to zero after reaching a programmable terminal value and flags the wrap with a one-cycle pulse.

Parameters:
- WIDTH, 8: bit width of the count register and `cnt_data`.
- MAX_VAL, 2**WIDTH-1 (255): terminal count; the counter wraps to 0 after this value. Legal range 1..2**WIDTH-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous reset, active-high. `rst_n`=1 at a rising edge resets the block (the `_n` suffix does not imply active-low here).
- cnt_en  input  1  count enable; 0 = counter disabled and cleared.
- pause  input  1  hold request; 1 = freeze current count.
- cnt_data  output  WIDTH  current count value, driven directly from the register.
- cnt_wrap  output  1  registered one-cycle pulse, high in the cycle after `cnt_data` transitions MAX_VAL -> 0.

Behaviour:
- Single clock domain; no asynchronous logic; all outputs registered.
- Reset (`rst_n`=1 at a clk rising edge): `cnt_data`=0, `cnt_wrap`=0. Reset has top priority and may be applied mid-count; the next value is 0 regardless of other inputs.
- Priority per rising edge: reset > `cnt_en`=0 > `pause`=1 > increment.
- `cnt_en`=0: `cnt_data` <= 0, `cnt_wrap` <= 0 (synchronous clear, independent of `pause`).
- `cnt_en`=1, `pause`=1: `cnt_data` holds its value; `cnt_wrap` <= 0.
- `cnt_en`=1, `pause`=0:
  - If `cnt_data` == MAX_VAL: `cnt_data` <= 0 and `cnt_wrap` <= 1.
  - Otherwise: `cnt_data` <= `cnt_data`+1 and `cnt_wrap` <= 0.
- Latency: one clock from input sampling to `cnt_data` update; the first increment after reset release or `pause` deassertion appears at the first rising edge where the inputs are sampled.
- `cnt_wrap` is high for exactly one cycle per wrap; it is never high while paused, disabled or in reset.
- Arithmetic is unsigned modulo (MAX_VAL+1); no saturation.
- If `cnt_data` somehow exceeds MAX_VAL (not possible from reset), the next enabled, non-paused edge loads 0 and pulses `cnt_wrap`.
- No X propagation: with X on `pause` or `cnt_en` while in reset, outputs remain 0.

Test Plan:
- Reset: hold `rst_n`=1 for 10 cycles with `cnt_en`=1, `pause`=0 -> `cnt_data`=0, `cnt_wrap`=0 throughout; release -> `cnt_data` reads 1, 2, 3 on successive edges.
- Wrap (default params): count freely from 0 -> after 255 edges `cnt_data`=255; next edge `cnt_data`=0 with `cnt_wrap`=1 for exactly one cycle; the following edge `cnt_data`=1, `cnt_wrap`=0.
- Pause: at `cnt_data`=20 assert `pause` for 5 cycles -> `cnt_data` stays 20; deassert -> 21 on the next edge. Pausing at 255 -> no wrap and no `cnt_wrap` pulse until unpaused.
- Enable clear: at `cnt_data`=50 drop `cnt_en` for 1 cycle with `pause`=1 -> `cnt_data`=0; re-enable -> 1, 2, ...
- Reset mid-operation: at `cnt_data`=100 pulse `rst_n`=1 for one edge -> `cnt_data`=0 on that edge, then counting resumes from 1.
- Non-default MAX_VAL=9, WIDTH=4: free count -> sequence 0..9, 0 with `cnt_wrap` pulsing on each 9 -> 0 transition (every 10 cycles).

Source files
------------

// File: rtl/pausable_counter_if.sv
// Control/status bundle for pausable_counter: enable/pause in, count/wrap out.
interface pausable_counter_if #(
  parameter int WIDTH = 8
);
  logic             cnt_en;
  logic             pause;
  logic [WIDTH-1:0] cnt_data;
  logic             cnt_wrap;

  // Controller side: drives enable/pause, observes count and wrap pulse.
  modport master (
    output cnt_en,
    output pause,
    input  cnt_data,
    input  cnt_wrap
  );

  // Counter side.
  modport slave (
    input  cnt_en,
    input  pause,
    output cnt_data,
    output cnt_wrap
  );
endinterface

// File: rtl/pausable_counter.sv
// Up-counter with synchronous clear (cnt_en=0), hold (pause=1) and a
// programmable terminal value. Wrap to 0 is flagged by a one-cycle pulse.
module pausable_counter #(
  parameter int          WIDTH   = 8,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic                clk,
  input  logic                rst_n,  // active-high synchronous reset
  pausable_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  // Next-state: reset > clear > hold > increment. A count at or above the
  // terminal value wraps, so an out-of-range value recovers on the next edge.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (rst_n) begin
      cnt_d  = '0;
      wrap_d = 1'b0;
    end else if (!bus.cnt_en) begin
      cnt_d  = '0;
      wrap_d = 1'b0;
    end else if (bus.pause) begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
    end else if (cnt_q >= MAX_V) begin
      cnt_d  = '0;
      wrap_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + WIDTH'(1);
      wrap_d = 1'b0;
    end
  end

  // State registers; reset term is already folded into the next-state logic,
  // repeated here so reset never depends on possibly-X control inputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.cnt_data = cnt_q;
  assign bus.cnt_wrap = wrap_q;

endmodule

// File: tb/tb_pausable_counter.sv
// Bench for pausable_counter: default 8-bit/255 instance and a 4-bit/9
// instance driven by the same controls, checked against a modulo model.
module tb_pausable_counter;

  logic clk = 1'b0;
  logic rst_n;
  logic en, pz;

  int total = 0;
  int bad   = 0;

  // Reference state for each instance.
  int m8 = 0, m4 = 0;
  int w8 = 0, w4 = 0;

  always #5 clk = ~clk;

  pausable_counter_if #(.WIDTH(8)) bus8 ();
  pausable_counter_if #(.WIDTH(4)) bus4 ();

  assign bus8.cnt_en = en;
  assign bus8.pause  = pz;
  assign bus4.cnt_en = en;
  assign bus4.pause  = pz;

  pausable_counter #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  pausable_counter #(.WIDTH(4), .MAX_VAL(9)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // Model one edge of a counter with terminal value mx.
  function automatic void model(input int mx, inout int m, inout int w,
                                input logic r, input logic e, input logic p);
    if (r === 1'b1 || e === 1'b0) begin
      m = 0; w = 0;
    end else if (p === 1'b1) begin
      w = 0;
    end else begin
      m = (m + 1) % (mx + 1);
      w = (m == 0) ? 1 : 0;
    end
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one edge, then sample 1 time unit after it.
  task automatic step(input logic r, input logic e, input logic p, input string tag);
    rst_n = r; en = e; pz = p;
    @(posedge clk);
    #1;
    model(255, m8, w8, r, e, p);
    model(9,   m4, w4, r, e, p);
    chk({tag, ".data8"}, int'(bus8.cnt_data), m8);
    chk({tag, ".wrap8"}, int'(bus8.cnt_wrap), w8);
    chk({tag, ".data4"}, int'(bus4.cnt_data), m4);
    chk({tag, ".wrap4"}, int'(bus4.cnt_wrap), w4);
  endtask

  // Count freely until the 8-bit model reaches target; bounded.
  task automatic run_to(input int target, input string tag);
    int n = 0;
    while (m8 != target && n < 600) begin
      step(1'b0, 1'b1, 1'b0, tag);
      n++;
    end
    total++;
    assert (m8 == target) else begin
      bad++;
      $error("FAIL %s.reach got=%0d exp=%0d", tag, m8, target);
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b1; pz = 1'b0;

    // Reset held for 10 edges, counting inputs active; X on controls too.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, "rst_hold");
    for (int i = 0; i < 3; i++) step(1'b1, 1'bx, 1'bx, "rst_x");
    chk("rst.data8_zero", int'(bus8.cnt_data), 0);

    // Release: 1, 2, 3.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "release");
    chk("release.data8_3", int'(bus8.cnt_data), 3);

    // Full wrap of the 8-bit instance; 4-bit one wraps every 10 edges.
    step(1'b1, 1'b1, 1'b0, "wrap_rst");
    run_to(255, "wrap_up");
    step(1'b0, 1'b1, 1'b0, "wrap_edge");
    chk("wrap.pulse8", int'(bus8.cnt_wrap), 1);
    step(1'b0, 1'b1, 1'b0, "wrap_after");
    chk("wrap.after8", int'(bus8.cnt_data), 1);

    // Pause at 20 for 5 edges, then resume to 21.
    step(1'b1, 1'b1, 1'b0, "p_rst");
    run_to(20, "p_up");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, "pause20");
    chk("pause.hold20", int'(bus8.cnt_data), 20);
    step(1'b0, 1'b1, 1'b0, "resume21");
    chk("pause.resume21", int'(bus8.cnt_data), 21);

    // Pause at the terminal value: no wrap while paused.
    run_to(255, "p255_up");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, "pause255");
    chk("pause255.nowrap", int'(bus8.cnt_wrap), 0);
    step(1'b0, 1'b1, 1'b0, "unpause255");
    chk("unpause255.wrap", int'(bus8.cnt_wrap), 1);

    // Enable clear at 50 with pause high; clear wins.
    run_to(50, "en_up");
    step(1'b0, 1'b0, 1'b1, "en_clear");
    chk("en.clear0", int'(bus8.cnt_data), 0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, "en_resume");
    chk("en.resume2", int'(bus8.cnt_data), 2);

    // Reset pulse at 100, then counting resumes from 1.
    run_to(100, "mid_up");
    step(1'b1, 1'b1, 1'b0, "mid_rst");
    step(1'b0, 1'b1, 1'b0, "mid_resume");
    chk("mid.resume1", int'(bus8.cnt_data), 1);

    // Random controls against the model.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 94),
           ($urandom_range(0, 99) < 20), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
